// File: rtl/f2_sdram_arbiter.sv
// f2_sdram_arbiter
//   Two-client SDRAM arbiter placed directly below the F2 top level. The CPU
//   (68000 ROM / work RAM, 16-bit read/write) and the TC0100SCN tile fetcher
//   (32-bit read, issued as a two-word burst) each talk to it through a toggle
//   handshake: a request is pending while req != ack. Pending requests are
//   serialised onto the single request/grant word port of the SDRAM controller.
//   Read data and the toggled ack go back to the client that owns the transfer.
//
// Ports
//   clk, reset_n                 clock, asynchronous active-low reset
//   cpu_addr/data/be/rw/req      CPU command and request toggle
//   cpu_ack, cpu_q               CPU ack toggle and read data
//   scn_addr, scn_req            SCN ROM word address and request toggle
//   scn_ack, scn_q               SCN ack toggle, {word at addr+1, word at addr}
//   sdr_addr/data/be/rw/len/req  command to the SDRAM controller, held until sdr_gnt
//   sdr_gnt                      one-cycle pulse: command accepted
//   sdr_q, sdr_rdy               read data, one rdy pulse per transferred word
//
// States
//   state   | meaning
//   S_IDLE  | sample pending toggles, arbitrate, latch the winner's command
//   S_ISSUE | sdr_req held high with a stable command until sdr_gnt
//   S_XFER  | count sdr_rdy beats; the last beat completes and toggles the ack

module f2_sdram_arbiter #(
  parameter logic [25:0] CPU_BASE    = 26'h0000000,
  parameter logic [25:0] SCN_BASE    = 26'h0100000,
  parameter int          MAX_SCN_RUN = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [25:0] cpu_addr,
  input  logic [15:0] cpu_data,
  input  logic [1:0]  cpu_be,
  input  logic        cpu_rw,
  input  logic        cpu_req,
  output logic        cpu_ack,
  output logic [15:0] cpu_q,
  input  logic [25:0] scn_addr,
  input  logic        scn_req,
  output logic        scn_ack,
  output logic [31:0] scn_q,
  output logic [25:0] sdr_addr,
  output logic [15:0] sdr_data,
  output logic [1:0]  sdr_be,
  output logic        sdr_rw,
  output logic        sdr_len,
  output logic        sdr_req,
  input  logic        sdr_gnt,
  input  logic [15:0] sdr_q,
  input  logic        sdr_rdy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_XFER  = 2'd2
  } state_t;

  localparam logic [3:0] MAX_RUN = 4'(MAX_SCN_RUN);

  state_t     state_q, state_d;
  logic       owner_scn;
  logic       beat_q;
  logic [3:0] run_q;

  logic cpu_pend, scn_pend;
  logic pick_scn, pick_cpu, gnt_take, rdy_lo, finish;

  assign cpu_pend = cpu_req ^ cpu_ack;
  assign scn_pend = scn_req ^ scn_ack;

  always_comb begin
    state_d  = state_q;
    pick_scn = 1'b0;
    pick_cpu = 1'b0;
    gnt_take = 1'b0;
    rdy_lo   = 1'b0;
    finish   = 1'b0;
    case (state_q)
      S_IDLE: begin
        // SCN has priority, except once it has taken MAX_RUN grants in a row
        // while the CPU was left waiting.
        if (scn_pend && !(cpu_pend && run_q == MAX_RUN)) begin
          pick_scn = 1'b1;
          state_d  = S_ISSUE;
        end else if (cpu_pend) begin
          pick_cpu = 1'b1;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (sdr_gnt) begin
          gnt_take = 1'b1;
          state_d  = S_XFER;
        end
      end
      S_XFER: begin
        if (sdr_rdy) begin
          if (owner_scn && !beat_q) begin
            rdy_lo = 1'b1;
          end else begin
            finish  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      owner_scn <= 1'b0;
      beat_q    <= 1'b0;
      run_q     <= 4'd0;
      cpu_ack   <= 1'b0;
      scn_ack   <= 1'b0;
      cpu_q     <= 16'd0;
      scn_q     <= 32'd0;
      sdr_addr  <= 26'd0;
      sdr_data  <= 16'd0;
      sdr_be    <= 2'd0;
      sdr_rw    <= 1'b0;
      sdr_len   <= 1'b0;
      sdr_req   <= 1'b0;
    end else begin
      state_q <= state_d;

      if (pick_scn) begin
        owner_scn <= 1'b1;
        beat_q    <= 1'b0;
        sdr_addr  <= scn_addr + SCN_BASE;
        sdr_be    <= 2'b11;
        sdr_rw    <= 1'b1;
        sdr_len   <= 1'b1;
        sdr_req   <= 1'b1;
      end

      if (pick_cpu) begin
        owner_scn <= 1'b0;
        beat_q    <= 1'b0;
        sdr_addr  <= cpu_addr + CPU_BASE;
        sdr_data  <= cpu_data;
        sdr_be    <= cpu_be;
        sdr_rw    <= cpu_rw;
        sdr_len   <= 1'b0;
        sdr_req   <= 1'b1;
      end

      if (gnt_take) sdr_req <= 1'b0;

      // The low half lands one beat early; the ack only moves on the last beat.
      if (rdy_lo) begin
        scn_q[15:0] <= sdr_q;
        beat_q      <= 1'b1;
      end

      if (finish) begin
        if (owner_scn) begin
          scn_q[31:16] <= sdr_q;
          scn_ack      <= ~scn_ack;
        end else begin
          if (sdr_rw) cpu_q <= sdr_q;
          cpu_ack <= ~cpu_ack;
        end
      end

      // Starvation counter: SCN grants taken while the CPU waits.
      if (pick_cpu) begin
        run_q <= 4'd0;
      end else if (state_q == S_IDLE && !cpu_pend) begin
        run_q <= 4'd0;
      end else if (pick_scn && run_q != 4'hF) begin
        run_q <= run_q + 4'd1;
      end
    end
  end

endmodule
